// File: rtl/sram_controller.sv
// Word-wide MEM-stage memory responder that serialises each 32-bit access into
// two 16-bit phases (low half, then high half) on an external asynchronous SRAM.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n
);

    localparam int P  = WAIT_CYCLES + 1;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     phase, phase_next;
    logic              op_wr, op_wr_next;
    logic [IW-1:0]     idx, idx_next, req_idx;
    logic [31:0]       wdata, wdata_next;
    logic [31:0]       read_data_next;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       dq_next;
    logic              we_n_next, oe_next;
    logic              last_phase;

    // Out-of-range addresses simply wrap into the SRAM word space.
    assign req_idx    = IW'((address - 32'(BASE_ADDR)) >> 2);
    assign last_phase = (phase == CW'(P - 1));
    assign ready      = (state == IDLE) ? ~(wr_en | rd_en) : (state == DONE);

    always_comb begin
        state_next     = state;
        phase_next     = phase;
        op_wr_next     = op_wr;
        idx_next       = idx;
        wdata_next     = wdata;
        read_data_next = read_data;
        addr_next      = sram_addr;
        dq_next        = sram_dq_out;
        we_n_next      = 1'b1;
        oe_next        = 1'b0;

        case (state)
            IDLE: begin
                if (wr_en | rd_en) begin
                    state_next = LOW;
                    phase_next = '0;
                    op_wr_next = wr_en;
                    idx_next   = req_idx;
                    wdata_next = write_data;
                end
            end
            LOW: begin
                if (last_phase) begin
                    if (!op_wr) read_data_next[15:0] = sram_dq_in;
                    state_next = HIGH;
                    phase_next = '0;
                end else begin
                    phase_next = phase + CW'(1);
                end
            end
            HIGH: begin
                if (last_phase) begin
                    if (!op_wr) read_data_next[31:16] = sram_dq_in;
                    state_next = DONE;
                    phase_next = '0;
                end else begin
                    phase_next = phase + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Pin values are computed for the upcoming state and registered, so the
        // write strobe never glitches.
        if (state_next == LOW) begin
            addr_next = {idx_next, 1'b0};
            we_n_next = ~op_wr_next;
            oe_next   = op_wr_next;
            if (op_wr_next) dq_next = wdata_next[15:0];
        end else if (state_next == HIGH) begin
            addr_next = {idx_next, 1'b1};
            we_n_next = ~op_wr_next;
            oe_next   = op_wr_next;
            if (op_wr_next) dq_next = wdata_next[31:16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            op_wr       <= op_wr_next;
            idx         <= idx_next;
            wdata       <= wdata_next;
            read_data   <= read_data_next;
            sram_addr   <= addr_next;
            sram_dq_out <= dq_next;
            sram_we_n   <= we_n_next;
            sram_dq_oe  <= oe_next;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomised scoreboard bench for sram_controller: a word-level reference memory
// predicts read results, SRAM pin traffic and transaction latency.
module tb_sram_controller;

    localparam int unsigned BASE_ADDR   = 1024;
    localparam int          ADDR_W      = 18;
    localparam int          WAIT_CYCLES = 1;
    localparam int          P           = WAIT_CYCLES + 1;
    localparam int          LAT         = 1 + 2 * P;
    localparam int unsigned NWORDS      = 1 << (ADDR_W - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [31:0]       address = '0;
    logic [31:0]       write_data = '0;
    logic [31:0]       read_data;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic [15:0]       sram_dq_in;
    logic              sram_dq_oe;
    logic              sram_we_n;

    sram_controller #(
        .BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #50 clk = ~clk;

    // External SRAM: combinational read, write sampled while the strobe is low.
    logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    // Reference model state.
    logic [31:0] ref_words [int unsigned];
    logic [31:0] ref_rd = '0;
    logic [31:0] exp_q[$];
    logic [ADDR_W+15:0] exp_pin_q[$];

    int total = 0;
    int bad = 0;
    int low_cnt = 0;

    function automatic logic [15:0] init_hw(input int unsigned k);
        return 16'(k * 37 + 5);
    endfunction

    function automatic logic [31:0] get_word(input int unsigned i);
        if (ref_words.exists(i)) return ref_words[i];
        return {init_hw(2 * i + 1), init_hw(2 * i)};
    endfunction

    function automatic int unsigned word_index(input logic [31:0] a);
        return ((a - BASE_ADDR) / 4) % NWORDS;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pins(input int unsigned i, input logic [31:0] d, input bit high_too);
        for (int c = 0; c < P; c++) exp_pin_q.push_back({ADDR_W'(2 * i), d[15:0]});
        if (high_too)
            for (int c = 0; c < P; c++) exp_pin_q.push_back({ADDR_W'(2 * i + 1), d[31:16]});
    endtask

    // mode: 0 hold request, 1 drop request after acceptance, 2 scramble inputs.
    task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input int mode);
        int unsigned i;
        bit seen;
        @(posedge clk); #10;
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        i = word_index(addr);
        if (wr) begin
            ref_words[i] = data;
            push_pins(i, data, 1'b1);
        end else begin
            ref_rd = get_word(i);
        end
        exp_q.push_back(ref_rd);
        if (mode != 0) begin
            @(posedge clk); #10;
            if (mode == 1) begin
                wr_en = 1'b0; rd_en = 1'b0;
            end else begin
                address = $urandom; write_data = $urandom;
                wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1));
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout: ready never returned for address %0h", addr);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #10;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Monitor: pin traffic, latency and read_data checked when a transaction ends.
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
        end else begin
            check("oe_vs_we_n", {63'd0, sram_dq_oe}, {63'd0, ~sram_we_n});
            if (!sram_we_n) begin
                if (exp_pin_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sram_write: unexpected strobe addr=%0h dq=%0h", sram_addr, sram_dq_out);
                end else begin
                    check("sram_write_pins", {30'd0, sram_addr, sram_dq_out}, {30'd0, exp_pin_q.pop_front()});
                end
            end
            if (!ready) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                check("latency", 64'(low_cnt), 64'(LAT));
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done: unexpected completion read_data=%0h", read_data);
                end else begin
                    check("read_data", {32'd0, read_data}, {32'd0, exp_q.pop_front()});
                end
                low_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, old;
        int k, r;
        for (int k2 = 0; k2 < (1 << ADDR_W); k2++) sram_mem[k2] = init_hw(k2);

        #40 rst = 1'b1;
        #40 rst = 1'b0;
        #20;  // t=100, negedge
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_we_n", {63'd0, sram_we_n}, 64'd1);
        check("reset_oe", {63'd0, sram_dq_oe}, 64'd0);
        check("reset_read_data", {32'd0, read_data}, 64'd0);
        check("reset_sram_addr", 64'(sram_addr), 64'd0);

        issue(1, 0, 32'd1024, 32'hDEADBEEF, 0);
        issue(0, 1, 32'd1024, 32'h0, 0);
        issue(1, 0, 32'd1032, 32'h12345678, 0);
        issue(0, 1, 32'd1035, 32'h0, 0);
        issue(1, 0, 32'd1035, 32'hCAFEF00D, 0);
        issue(0, 1, 32'd1032, 32'h0, 0);
        issue(1, 1, 32'd1028, 32'hA5A55A5A, 1);
        issue(0, 1, 32'd1028, 32'h0, 2);
        issue(1, 0, 32'd0, 32'h0BADF00D, 0);
        issue(0, 1, 32'd1020, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            if (k < 8)      a = BASE_ADDR + 4 * $urandom_range(0, 15);
            else if (k == 8) a = BASE_ADDR - 4 * $urandom_range(1, 4);
            else            a = BASE_ADDR + 4 * (NWORDS + $urandom_range(0, 3));
            a = a + 32'($urandom_range(0, 3));
            d = $urandom;
            r = $urandom_range(0, 3);
            issue(r < 2 || r == 3, r >= 2, a, d, $urandom_range(0, 2));
        end

        // Make read_data non-zero, then reset in the first HIGH cycle of a write.
        issue(0, 1, 32'd1024, 32'h0, 0);
        @(posedge clk); #10;
        d = $urandom;
        old = get_word(3);
        wr_en = 1'b1; rd_en = 1'b0; address = BASE_ADDR + 12; write_data = d;
        ref_words[3] = {old[31:16], d[15:0]};
        push_pins(3, d, 1'b0);
        @(posedge clk);
        repeat (P) @(posedge clk);
        #10 rst = 1'b1; wr_en = 1'b0;
        #5;
        check("midreset_we_n", {63'd0, sram_we_n}, 64'd1);
        check("midreset_oe", {63'd0, sram_dq_oe}, 64'd0);
        check("midreset_read_data", {32'd0, read_data}, 64'd0);
        check("midreset_ready", {63'd0, ready}, 64'd1);
        #55 rst = 1'b0;
        ref_rd = '0;

        issue(0, 1, BASE_ADDR + 12, 32'h0, 0);
        issue(0, 1, 32'd1024, 32'h0, 0);
        go_idle();
        repeat (3) @(negedge clk);

        foreach (ref_words[i])
            check("sram_word", {32'd0, sram_mem[2 * i + 1], sram_mem[2 * i]}, {32'd0, ref_words[i]});
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("pin_q_drained", 64'(exp_pin_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the ARM pipeline's MEM stage.
- Accepts 32-bit word read/write requests and serialises each into two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low while a transaction is in progress so the pipeline freezes.
- Replaces the single-cycle data memory; sits between the MEM stage and the SRAM pins.

Parameters:
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.
- ADDR_W, 18, SRAM address bus width (16-bit halfword granularity).
- WAIT_CYCLES, 1, extra cycles each SRAM phase is held (phase length P = WAIT_CYCLES+1, P ≥ 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  MEM-stage word write request.
- rd_en  in  1  MEM-stage word read request.
- address  in  32  CPU byte address; bits [1:0] ignored.
- write_data  in  32  word to store.
- read_data  out  32  last completed read word.
- ready  out  1  high = no transaction pending, pipeline may advance.
- sram_addr  out  ADDR_W  SRAM halfword address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned by SRAM.
- sram_dq_oe  out  1  high = controller drives the DQ bus.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state=IDLE, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready is combinational and evaluates to 1 in IDLE with no request.
- States: IDLE, LOW, HIGH, DONE. A phase counter counts 0..P-1 within LOW and HIGH.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational, so the stall is visible in the request cycle.
  - If a request is present, latch op, word index, and write_data, then go to LOW.
  - Word index = (address − BASE_ADDR) >> 2, truncated to ADDR_W−1 bits; out-of-range addresses wrap modulo.
  - wr_en and rd_en both high: write wins, no read occurs.
- LOW:
  - sram_addr = {index, 1'b0}.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out = latched data[15:0].
  - Read: sram_we_n=1, sram_dq_oe=0; on the last phase cycle capture sram_dq_in into read_data[15:0].
  - After P cycles go to HIGH.
- HIGH:
  - Same as LOW, with sram_addr = {index, 1'b1} and data[31:16] / read_data[31:16].
  - After P cycles go to DONE.
- DONE:
  - ready=1 for exactly one cycle; sram_we_n=1, sram_dq_oe=0.
  - The pipeline advances on this edge. Next state is IDLE unconditionally, so the same request is never re-accepted.
- Latency: ready is low for 1+2P cycles (5 with defaults), high in the DONE cycle.
- Changes to request inputs after acceptance are ignored; the latched transaction completes.
- read_data:
  - Valid from the DONE cycle of a read.
  - Held until the next read overwrites it; writes never change it.
  - The upper half retains its old value while the LOW phase is in progress.
- sram_we_n is driven only from registered state; no glitches.
- sram_dq_oe is never 1 during a read phase.

Test Plan:
- Reset then idle → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0; rst pulses 40 ns after start for 40 ns, clock period 100 ns.
- Write 0xDEADBEEF to address 1024 →
  - ready low 5 cycles.
  - sram_addr=0 with dq_out=0xBEEF, we_n=0 for 2 cycles.
  - Then sram_addr=1 with dq_out=0xDEAD, we_n=0 for 2 cycles.
  - Then ready=1 for 1 cycle.
- Read address 1024 with the SRAM model holding 0xBEEF at 0 and 0xDEAD at 1 → read_data=0xDEADBEEF in the DONE cycle, dq_oe=0 throughout.
- Write 0x12345678 to address 1032 (index 2) → halfword addresses 4 and 5 receive 0x5678 and 0x1234; address[1:0]=2'b11 gives the same result.
- wr_en and rd_en asserted together, and the request dropped during LOW → write performed, read_data unchanged, transaction still completes in 5 cycles.
- rst asserted during the HIGH phase of a write → immediately IDLE, we_n=1, dq_oe=0, read_data=0; halfword 1 not written.
